// File: rtl/register16_serializer.sv
// Parallel-in/serial-out transmitter: captures a word on a valid/ready handshake and
// shifts it out one bit per clock with first/last framing strobes.
module register16_serializer #(
   parameter int unsigned WIDTH     = 16,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             sout_first,
   output logic             sout_last,
   output logic             busy
);

   localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic {StIdle, StShift} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             last_bit;
   logic             accept;
   logic [WIDTH-1:0] shreg_shifted;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs decode only registered state, so no input reaches an output combinationally.
   always_comb begin
      last_bit   = (state_q == StShift) && (cnt_q == LastCnt);
      load_ready = (state_q == StIdle) || last_bit;
      busy       = (state_q == StShift);
      sout_valid = (state_q == StShift);
      sout_first = (state_q == StShift) && (cnt_q == '0);
      sout_last  = last_bit;
      sout       = (state_q == StShift) && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
   end

   always_comb begin
      accept        = load_valid && load_ready;
      shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
      state_d       = state_q;
      shreg_d       = shreg_q;
      cnt_d         = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               shreg_d = d;
               cnt_d   = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            if (accept) begin
               // Accepting on the last bit keeps the stream gapless.
               shreg_d = d;
               cnt_d   = '0;
            end else if (last_bit) begin
               shreg_d = shreg_shifted;
               cnt_d   = '0;
               state_d = StIdle;
            end else begin
               shreg_d = shreg_shifted;
               cnt_d   = cnt_q + CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

endmodule
